calib_ram_responder: RTL and testbench
======================================

CALIB_RAM_RESPONDER -- requirements
Module: calib_ram_responder

Interface
REQ-001 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- cal_address  in  9  calibration read word address, from the reconstruction master
- cal_read  in  1  read request, held by the master until waitrequest is low
- cal_readdata  out  16  calibration word; valid when cal_read=1 and cal_waitrequest=0
- cal_waitrequest  out  1  stall for the read master
- load_address  in  9  host load word address
- load_write  in  1  host write strobe, single cycle
- load_writedata  in  16  host load data
- clear_start  in  1  pulse; starts a zero-fill of the whole table
- busy  out  1  high while a clear is in progress
- checksum  out  16  running sum of accepted writes (see REQ-020)

REQ-002 SHALL use one clock domain, with synchronous active-high reset exactly as in REQ-001.

Function
REQ-003 SHALL hold a 512 x 16 calibration table with one read port and one write port.

REQ-004 SHALL implement the states IDLE, FETCH, DONE and CLEAR.

REQ-005 SHALL drive cal_waitrequest combinationally as 1 in every state except DONE, and as 1 in DONE only if cal_read=0.

REQ-006 SHALL handle reads in three steps:
- IDLE with cal_read=1: latch cal_address, issue the table read, go to FETCH.
- FETCH: register the table output into cal_readdata, go to DONE.
- DONE: the transfer completes; unconditionally return to IDLE next cycle.

REQ-007 SHALL complete a read in exactly 3 cycles from cal_read rising in IDLE to the cycle in which cal_waitrequest=0.

REQ-008 SHALL hold cal_readdata stable from DONE until the next FETCH completes.

REQ-009 SHALL accept a load_write in any state except CLEAR; writes during CLEAR are dropped and do not affect checksum.

REQ-010 SHALL, when load_write targets the latched address in the same cycle the read is issued (IDLE->FETCH), return load_writedata to the master (write-first bypass).

REQ-011 SHALL, for a write to the latched address while in FETCH or DONE, not alter the word already being returned.

REQ-012 SHALL act on clear_start only in IDLE, entering CLEAR; clear_start in any other state SHALL be ignored.

REQ-013 SHALL, in CLEAR, write 0x0000 to addresses 0..511 using a 9-bit counter (512 cycles), then return to IDLE; busy=1 throughout.

REQ-014 SHALL stall any cal_read arriving during CLEAR with cal_waitrequest=1 until CLEAR ends, then service it normally.

REQ-015 SHALL wrap address arithmetic modulo 512; the clear counter terminates at 511 and does not wrap.

Reset
REQ-016 SHALL apply the following values during and after rst: state=IDLE, cal_readdata=0x0000, cal_waitrequest=1 while rst=1, busy=0, checksum=0x0000, clear counter=0.

REQ-017 SHALL abandon any in-flight read or clear on rst; the master reissues, and a partially cleared table stays partially cleared.

REQ-018 SHALL NOT initialise table contents on reset; contents change only through writes or CLEAR.

Configuration
REQ-019 SHALL compile the checksum feature in or out under macro CALIB_CHECKSUM_EN.

REQ-020 SHALL, with CALIB_CHECKSUM_EN defined, add each accepted load_writedata to checksum modulo 2^16 in the cycle after the write, and reset checksum to 0 when CLEAR completes.

REQ-021 SHALL, without CALIB_CHECKSUM_EN, tie checksum to 0x0000 and instantiate no accumulator.

Structure
REQ-022 SHALL take the constants CAL_ADDR_W=9, CAL_DATA_W=16, CAL_DEPTH=512 and the state enum from the shared package calib_ram_pkg.

REQ-023 SHALL place the memory in sub-module calib_ram_dp: simple dual-port, synchronous read, 1-cycle latency, no read/write bypass; the bypass of REQ-010 lives in calib_ram_responder.

Verification
REQ-024 SHALL cover the following directed scenarios:
- Write 0x1234 to addr 5, then read addr 5: cal_waitrequest low exactly 3 cycles after cal_read rises, readdata=0x1234.
- Read addr 7 with a simultaneous write of 0xBEEF to addr 7 in the issue cycle: readdata=0xBEEF.
- Write 0xAAAA to addr 511, then clear_start: busy high 512 cycles; a read of addr 511 issued during busy stalls, then returns 0x0000.
- Write during CLEAR: dropped; after CLEAR, readback=0x0000 and checksum=0.
- With CALIB_CHECKSUM_EN, write 0xFFFF then 0x0002: checksum=0x0001; without the macro, checksum=0.
- Assert rst while in FETCH: next cycle state=IDLE, readdata=0, cal_waitrequest=1 while rst is high; a reissued read completes normally.

Source files
------------

// File: rtl/calib_ram_pkg.sv
// Shared constants and FSM state type for the calibration RAM responder.
package calib_ram_pkg;

    localparam int CAL_ADDR_W = 9;
    localparam int CAL_DATA_W = 16;
    localparam int CAL_DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/calib_ram_responder_if.sv
// Bus bundle between the reconstruction master / host loader and the calibration RAM responder.
interface calib_ram_responder_if;
    import calib_ram_pkg::*;

    // Read handshake: the master holds cal_read and cal_address until it sees
    // cal_waitrequest low while cal_read is high; cal_readdata is valid in that cycle.
    logic [CAL_ADDR_W-1:0] cal_address;
    logic                  cal_read;
    logic [CAL_DATA_W-1:0] cal_readdata;
    logic                  cal_waitrequest;
    logic [CAL_ADDR_W-1:0] load_address;
    logic                  load_write;
    logic [CAL_DATA_W-1:0] load_writedata;
    logic                  clear_start;
    logic                  busy;
    logic [CAL_DATA_W-1:0] checksum;

    modport master (
        output cal_address, cal_read, load_address, load_write, load_writedata, clear_start,
        input  cal_readdata, cal_waitrequest, busy, checksum
    );

    modport slave (
        input  cal_address, cal_read, load_address, load_write, load_writedata, clear_start,
        output cal_readdata, cal_waitrequest, busy, checksum
    );

endinterface

// File: rtl/calib_ram_dp.sv
// 512x16 simple dual-port table: one write port, one registered read port, no bypass.
module calib_ram_dp
    import calib_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [CAL_ADDR_W-1:0] wr_addr,
    input  logic [CAL_DATA_W-1:0] wr_data,
    input  logic                  re,
    input  logic [CAL_ADDR_W-1:0] rd_addr,
    output logic [CAL_DATA_W-1:0] rd_data
);

    logic [CAL_DATA_W-1:0] mem_q [CAL_DEPTH];
    logic [CAL_DATA_W-1:0] rd_data_q;

    // Contents are deliberately never reset; a read of the address being written returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
        if (re) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/calib_ram_responder.sv
// Calibration table responder: 3-cycle reads with write-first bypass, host loads, table clear.
// Optional running checksum of accepted writes is built only with CALIB_CHECKSUM_EN defined.
module calib_ram_responder
    import calib_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    calib_ram_responder_if.slave bus,
    output state_e               dbg_state
);

    state_e                state_q, state_d;
    logic [CAL_DATA_W-1:0] readdata_q, readdata_d;
    logic                  byp_q, byp_d;
    logic [CAL_DATA_W-1:0] byp_data_q, byp_data_d;
    logic [CAL_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic                  wr_accept;
    logic                  clear_done;
    logic                  ram_we;
    logic [CAL_ADDR_W-1:0] ram_waddr;
    logic [CAL_DATA_W-1:0] ram_wdata;
    logic                  ram_re;
    logic [CAL_DATA_W-1:0] ram_rd_data;

    assign wr_accept  = bus.load_write && (state_q != CLEAR);
    assign clear_done = (state_q == CLEAR) && (clr_cnt_q == CAL_ADDR_W'(CAL_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        clr_cnt_d  = clr_cnt_q;
        ram_re     = 1'b0;
        ram_we     = wr_accept;
        ram_waddr  = bus.load_address;
        ram_wdata  = bus.load_writedata;

        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (bus.cal_read) begin
                    state_d    = FETCH;
                    ram_re     = 1'b1;
                    // The RAM returns the pre-write word, so a same-cycle write to the read address is captured here.
                    byp_d      = bus.load_write && (bus.load_address == bus.cal_address);
                    byp_data_d = bus.load_writedata;
                end
            end
            FETCH: begin
                readdata_d = byp_q ? byp_data_q : ram_rd_data;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
                if (clear_done) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CAL_ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            readdata_q <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    calib_ram_dp u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .re      (ram_re),
        .rd_addr (bus.cal_address),
        .rd_data (ram_rd_data)
    );

`ifdef CALIB_CHECKSUM_EN
    logic [CAL_DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (clear_done)     checksum_d = '0;
        else if (wr_accept) checksum_d = checksum_q + bus.load_writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.cal_readdata    = readdata_q;
    assign bus.cal_waitrequest = rst || !((state_q == DONE) && bus.cal_read);
    assign bus.busy            = (state_q == CLEAR);
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_calib_ram_responder.sv
// Directed and table-driven bench for calib_ram_responder with a read-data scoreboard.
module tb_calib_ram_responder;
    import calib_ram_pkg::*;

    logic   clk;
    logic   rst;
    state_e dbg_state;

    calib_ram_responder_if bus ();

    calib_ram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [CAL_DEPTH];
    logic [15:0] ck_exp = 16'h0000;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ck_want();
`ifdef CALIB_CHECKSUM_EN
        return ck_exp;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic do_write(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.load_write     = 1'b1;
        bus.load_address   = a;
        bus.load_writedata = d;
        model[a] = d;
        ck_exp   = ck_exp + d;
        @(negedge clk);
        bus.load_write = 1'b0;
    endtask

    // side: 0 plain, 1 write same address in issue cycle, 2 write same address in FETCH, 3 clear_start in FETCH
    task automatic do_read(input logic [8:0] a, input int side, input logic [15:0] wd, input string nm);
        logic [15:0] exp;
        logic [15:0] got_exp;
        int cyc;
        bit done;
        exp = (side == 1) ? wd : model[a];
        exp_q.push_back(exp);
        @(negedge clk);
        bus.cal_read    = 1'b1;
        bus.cal_address = a;
        if (side == 1) begin
            bus.load_write = 1'b1; bus.load_address = a; bus.load_writedata = wd;
            model[a] = wd; ck_exp = ck_exp + wd;
        end
        cyc  = 1;
        done = 1'b0;
        #1;
        while (!done && cyc <= 2000) begin
            if (!bus.cal_waitrequest) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                bus.load_write  = 1'b0;
                bus.clear_start = 1'b0;
                cyc++;
                if (cyc == 2 && side == 2) begin
                    bus.load_write = 1'b1; bus.load_address = a; bus.load_writedata = wd;
                    ck_exp = ck_exp + wd;
                end
                if (cyc == 2 && side == 3) bus.clear_start = 1'b1;
                #1;
            end
        end
        got_exp = exp_q.pop_front();
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_lat"}, 32'(cyc), 32'd3);
        chk({nm, "_data"}, 32'(bus.cal_readdata), 32'(got_exp));
        bus.cal_read = 1'b0;
        if (side == 2) model[a] = wd;
        if (side == 3) begin
            @(negedge clk);
            chk({nm, "_clr_ignored"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int busy_cnt;
        int stall_cnt;
        bit got_done;
        logic [15:0] e;
        logic [8:0]  ra [6];

        vecs[0] = '{9'd5,   16'h1234, 16'h1234};
        vecs[1] = '{9'd0,   16'h0001, 16'h0001};
        vecs[2] = '{9'd511, 16'hAAAA, 16'hAAAA};
        vecs[3] = '{9'd256, 16'h8000, 16'h8000};
        vecs[4] = '{9'd1,   16'h7FFF, 16'h7FFF};
        vecs[5] = '{9'd300, 16'h5A5A, 16'h5A5A};

        rst = 1'b1;
        bus.cal_address = '0; bus.cal_read = 1'b0;
        bus.load_address = '0; bus.load_write = 1'b0; bus.load_writedata = '0;
        bus.clear_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_readdata", 32'(bus.cal_readdata), 32'h0);
        chk("rst_waitreq", 32'(bus.cal_waitrequest), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_checksum", 32'(bus.checksum), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_waitreq", 32'(bus.cal_waitrequest), 32'd1);

        // Table-driven write then readback
        for (int i = 0; i < 6; i++) do_write(vecs[i].addr, vecs[i].wdata);
        chk("table_checksum", 32'(bus.checksum), 32'(ck_want()));
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_rd);
            e = exp_q.pop_front();
            chk("table_model", 32'(model[vecs[i].addr]), 32'(e));
            do_read(vecs[i].addr, 0, 16'h0, $sformatf("table_rd%0d", i));
        end

        // Readdata holds after the transfer
        repeat (3) @(negedge clk);
        chk("readdata_hold", 32'(bus.cal_readdata), 32'h5A5A);

        do_read(9'd7, 1, 16'hBEEF, "bypass_issue");
        chk("bypass_checksum", 32'(bus.checksum), 32'(ck_want()));
        do_read(9'd5, 2, 16'h4321, "fetch_write");
        do_read(9'd5, 0, 16'h0, "fetch_write_after");
        do_read(9'd0, 3, 16'h0, "clr_in_fetch");

        // Reset while in FETCH abandons the read; table keeps its contents
        @(negedge clk);
        bus.cal_read = 1'b1; bus.cal_address = 9'd256;
        @(negedge clk);
        chk("pre_rst_fetch", 32'(dbg_state), 32'(FETCH));
        rst = 1'b1;
        #1;
        chk("rst_fetch_waitreq", 32'(bus.cal_waitrequest), 32'd1);
        @(negedge clk);
        chk("rst_fetch_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_fetch_readdata", 32'(bus.cal_readdata), 32'h0);
        chk("rst_fetch_waitreq2", 32'(bus.cal_waitrequest), 32'd1);
        chk("rst_fetch_checksum", 32'(bus.checksum), 32'h0);
        ck_exp = 16'h0000;
        bus.cal_read = 1'b0;
        rst = 1'b0;
        do_read(9'd256, 0, 16'h0, "reissue");
        do_read(9'd5, 0, 16'h0, "table_survives_rst");

        // Clear with a stalled read and a dropped write
        do_write(9'd511, 16'hAAAA);
        @(negedge clk);
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        bus.cal_read = 1'b1; bus.cal_address = 9'd511;
        bus.load_write = 1'b1; bus.load_address = 9'd100; bus.load_writedata = 16'h5555;
        exp_q.push_back(16'h0000);
        busy_cnt = 0; stall_cnt = 0; got_done = 1'b0;
        #1;
        for (int c = 0; c < 2000; c++) begin
            if (bus.busy) busy_cnt++;
            if (!bus.cal_waitrequest) begin
                got_done = 1'b1;
                break;
            end
            stall_cnt++;
            @(negedge clk);
            bus.load_write = 1'b0;
            #1;
        end
        e = exp_q.pop_front();
        chk("clear_rd_done", 32'(got_done), 32'd1);
        chk("clear_rd_data", 32'(bus.cal_readdata), 32'(e));
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd512);
        chk("clear_stall_cycles", 32'(stall_cnt), 32'd514);
        bus.cal_read = 1'b0;
        for (int i = 0; i < CAL_DEPTH; i++) model[i] = 16'h0000;
        ck_exp = 16'h0000;
        @(negedge clk);
        chk("clear_checksum", 32'(bus.checksum), 32'h0);
        do_read(9'd100, 0, 16'h0, "clear_dropped_wr");
        do_read(9'd0, 0, 16'h0, "clear_addr0");

        do_write(9'd20, 16'hFFFF);
        do_write(9'd21, 16'h0002);
        chk("checksum_wrap", 32'(bus.checksum), 32'(ck_want()));

        // Random traffic on the cleared table
        for (int i = 0; i < 6; i++) begin
            ra[i] = 9'($urandom_range(0, CAL_DEPTH - 1));
            do_write(ra[i], 16'($urandom_range(0, 16'hFFFF)));
        end
        chk("rand_checksum", 32'(bus.checksum), 32'(ck_want()));
        for (int i = 0; i < 6; i++) do_read(ra[i], 0, 16'h0, $sformatf("rand_rd%0d", i));
        do_read(9'($urandom_range(0, CAL_DEPTH - 1)), 1, 16'($urandom_range(0, 16'hFFFF)), "rand_bypass");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
